// File: rtl/rr_octal_grant_arbiter.sv
// Round-robin arbiter for 8 requesters with owner hold and optional hold timeout.
// All outputs are registered; a release always leaves one idle cycle before the next grant.
module rr_octal_grant_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  localparam int unsigned CntW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CntW-1:0] HoldMax = CntW'(MAX_HOLD);
  localparam bit HoldEn = (MAX_HOLD > 0);

  typedef enum logic {StIdle, StGrant} state_t;

  state_t          state;
  logic [2:0]      ptr;
  logic [CntW-1:0] hold_cnt;

  logic       pick_found;
  logic [2:0] pick_idx;
  logic [2:0] cand;
  logic       owner_req;
  logic       hold_expired;

  // Scan from the highest offset down so the candidate closest to ptr wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 3'd0;
    cand       = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      cand = ptr + 3'(i);
      if (req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // grant_idx doubles as the owner index while in StGrant.
  assign owner_req    = req[grant_idx];
  assign hold_expired = HoldEn && (hold_cnt == HoldMax);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      ptr         <= 3'd0;
      hold_cnt    <= '0;
      grant       <= 8'd0;
      grant_idx   <= 3'd0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        StIdle: begin
          if (pick_found) begin
            state       <= StGrant;
            grant       <= 8'd1 << pick_idx;
            grant_idx   <= pick_idx;
            grant_valid <= 1'b1;
            hold_cnt    <= CntW'(1);
          end
        end
        StGrant: begin
          if (!owner_req || hold_expired) begin
            state       <= StIdle;
            ptr         <= grant_idx + 3'd1;
            grant       <= 8'd0;
            grant_idx   <= 3'd0;
            grant_valid <= 1'b0;
            hold_cnt    <= '0;
            timeout     <= owner_req;
          end else if (hold_cnt != '1) begin
            // Saturate rather than wrap when there is no timeout.
            hold_cnt <= hold_cnt + CntW'(1);
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
